// File: rtl/axil_detector_regbank.sv
// rtl/axil_detector_regbank.sv - AXI4-Lite config/status/interrupt register bank for detector IPs
module axil_detector_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_RW             = 4,
  parameter int NUM_RO             = 2,
  parameter int IRQ_BITS           = 4,
  parameter logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] RW_RESET = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0]   cfg_out,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]   status_in,
  input  logic [IRQ_BITS-1:0]                    event_in,
  output logic                                   irq
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IW       = AW - ADDR_LSB;
  localparam int LAST_IDX = NUM_RW + NUM_RO + 1;
  localparam logic [IW-1:0] IDX_STAT = IW'(NUM_RW + NUM_RO);
  localparam logic [IW-1:0] IDX_EN   = IW'(LAST_IDX);

  logic [NUM_RW*DW-1:0] cfg_q;
  logic [IRQ_BITS-1:0]  irq_stat, irq_en, stat_clr;
  logic                 aw_done, w_done, wr_fire;
  logic [IW-1:0]        awidx_q, ridx;
  logic [DW-1:0]        wdata_q, bit_mask, rd_val;
  logic [SW-1:0]        wstrb_q;
  logic                 rd_err;
  logic                 unused_ok;

  assign wr_fire   = aw_done && w_done;
  assign ridx      = S_AXI_ARADDR[AW-1:ADDR_LSB];
  assign cfg_out   = cfg_q;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Capture the write address; AWREADY comes back once the B handshake retires
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      aw_done       <= 1'b0;
      awidx_q       <= '0;
    end else if (S_AXI_AWREADY && S_AXI_AWVALID) begin
      S_AXI_AWREADY <= 1'b0;
      aw_done       <= 1'b1;
      awidx_q       <= S_AXI_AWADDR[AW-1:ADDR_LSB];
    end else if (wr_fire) begin
      aw_done       <= 1'b0;
    end else if (!aw_done && (!S_AXI_BVALID || S_AXI_BREADY)) begin
      S_AXI_AWREADY <= 1'b1;
    end
  end

  // Capture write data and strobes independently of the address
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_WREADY <= 1'b0;
      w_done       <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else if (S_AXI_WREADY && S_AXI_WVALID) begin
      S_AXI_WREADY <= 1'b0;
      w_done       <= 1'b1;
      wdata_q      <= S_AXI_WDATA;
      wstrb_q      <= S_AXI_WSTRB;
    end else if (wr_fire) begin
      w_done       <= 1'b0;
    end else if (!w_done && (!S_AXI_BVALID || S_AXI_BREADY)) begin
      S_AXI_WREADY <= 1'b1;
    end
  end

  // Issue the write response once both halves are in; indices past IRQ_EN are errors
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
    end else if (wr_fire) begin
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= (int'(awidx_q) > LAST_IDX) ? 2'b10 : 2'b00;
    end else if (S_AXI_BVALID && S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
    end
  end

  // Expand byte strobes to a bit mask and derive the write-1-to-clear vector
  always_comb begin
    bit_mask = '0;
    stat_clr = '0;
    for (int b = 0; b < DW; b++) bit_mask[b] = wstrb_q[b/8];
    if (wr_fire && awidx_q == IDX_STAT)
      stat_clr = wdata_q[IRQ_BITS-1:0] & bit_mask[IRQ_BITS-1:0];
  end

  // Config, interrupt enable and interrupt status storage plus the registered irq level
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cfg_q    <= RW_RESET;
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      // A new event wins over a simultaneous clear of the same bit
      irq_stat <= (irq_stat & ~stat_clr) | event_in;
      irq      <= |(irq_stat & irq_en);
      if (wr_fire) begin
        for (int i = 0; i < NUM_RW; i++)
          if (awidx_q == IW'(i))
            cfg_q[i*DW +: DW] <= (cfg_q[i*DW +: DW] & ~bit_mask) | (wdata_q & bit_mask);
        if (awidx_q == IDX_EN)
          irq_en <= (irq_en & ~bit_mask[IRQ_BITS-1:0]) |
                    (wdata_q[IRQ_BITS-1:0] & bit_mask[IRQ_BITS-1:0]);
      end
    end
  end

  // Read decode from current register state, so a same-edge write is not yet visible
  always_comb begin
    rd_val = '0;
    rd_err = int'(ridx) > LAST_IDX;
    for (int i = 0; i < NUM_RW; i++)
      if (ridx == IW'(i)) rd_val = cfg_q[i*DW +: DW];
    for (int i = 0; i < NUM_RO; i++)
      if (ridx == IW'(NUM_RW + i)) rd_val = status_in[i*DW +: DW];
    if (ridx == IDX_STAT) rd_val[IRQ_BITS-1:0] = irq_stat;
    if (ridx == IDX_EN)   rd_val[IRQ_BITS-1:0] = irq_en;
  end

  // Read channel: register data at the AR handshake and hold it until RREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else if (S_AXI_ARREADY && S_AXI_ARVALID) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b1;
      S_AXI_RDATA   <= rd_val;
      S_AXI_RRESP   <= rd_err ? 2'b10 : 2'b00;
    end else if (!S_AXI_RVALID || S_AXI_RREADY) begin
      S_AXI_RVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axil_detector_regbank.sv
// tb/tb_axil_detector_regbank.sv - directed self-checking bench for axil_detector_regbank
module tb_axil_detector_regbank;
  localparam logic [127:0] RST_VAL = 128'hDEAD0003_CAFE0002_BEEF0001_12345678;

  logic         clk = 1'b0, areset = 1'b1;
  logic [5:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic         awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0, event_in = '0;
  logic [1:0]   bresp, rresp;
  logic [127:0] cfg_out;
  logic [63:0]  status_in = {32'hBBBB_0005, 32'hAAAA_0004};
  int           total = 0, bad = 0;

  always #5 clk = ~clk;

  axil_detector_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_RW(4), .NUM_RO(2),
    .IRQ_BITS(4), .RW_RESET(RST_VAL)
  ) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_out(cfg_out), .status_in(status_in), .event_in(event_in), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_pend, w_pend, aw_hs, w_hs, got_b;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 0;
    aw_pend = 1; w_pend = 1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_hs = aw_pend && awready;
      w_hs  = w_pend && wready;
      tick(); n++;
      if (aw_hs) begin awvalid = 0; aw_pend = 0; end
      if (w_hs)  begin wvalid = 0;  w_pend = 0;  end
    end
    while (!bvalid && n < 40) begin tick(); n++; end
    got_b = bvalid;
    resp = bresp;
    bready = 1; tick(); bready = 0;
    awvalid = 0; wvalid = 0;
    total++;
    if (got_b !== 1'b1) begin
      bad++;
      $display("FAIL write_handshake addr=%h got bvalid=%b required 1 within 40 cycles", addr, got_b);
    end
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic got_r;
    araddr = addr; arvalid = 1; rready = 0; n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick(); n++;
    arvalid = 0;
    while (!rvalid && n < 40) begin tick(); n++; end
    got_r = rvalid; data = rdata; resp = rresp;
    rready = 1; tick(); rready = 0;
    total++;
    if (got_r !== 1'b1) begin
      bad++;
      $display("FAIL read_handshake addr=%h got rvalid=%b required 1 within 40 cycles", addr, got_r);
    end
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    total++;
    if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b required=000000", {awready, wready, arready, bvalid, rvalid, irq});
    end
    total++;
    if (cfg_out !== RST_VAL) begin bad++; $display("FAIL reset_cfg got=%h required=%h", cfg_out, RST_VAL); end
    total++;
    if ({rdata, rresp, bresp} !== 36'h0) begin
      bad++; $display("FAIL reset_data got=%h required=0", {rdata, rresp, bresp});
    end
    areset = 0;
    tick();
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL reset_release_ready got=%b required=111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i*4), 32'(i+1), 4'hF, r);
      total++;
      if (r !== 2'b00) begin bad++; $display("FAIL basic_bresp idx=%0d got=%b required=00", i, r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i*4), d, r);
      total++;
      if (d !== 32'(i+1) || r !== 2'b00) begin
        bad++; $display("FAIL basic_read idx=%0d got=%h/%b required=%h/00", i, d, r, i+1);
      end
    end
    total++;
    if (cfg_out !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
      bad++; $display("FAIL basic_cfg_out got=%h required=%h", cfg_out, {32'h4, 32'h3, 32'h2, 32'h1});
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1; bready = 0;
    tick(); wvalid = 0;
    tick(); tick();
    total++;
    if ({bvalid, awready, wready} !== 3'b010) begin
      bad++; $display("FAIL wfirst_wait got=%b required=010", {bvalid, awready, wready});
    end
    awaddr = 6'h04; awvalid = 1;
    tick(); awvalid = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({bvalid, awready, wready} !== 3'b100) begin
        bad++; $display("FAIL wfirst_bhold cyc=%0d got=%b required=100", k, {bvalid, awready, wready});
      end
      tick();
    end
    total++;
    if (cfg_out[63:32] !== 32'h55) begin bad++; $display("FAIL wfirst_cfg got=%h required=00000055", cfg_out[63:32]); end
    bready = 1; tick(); bready = 0;
    total++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      bad++; $display("FAIL wfirst_after_b got=%b required=011", {bvalid, awready, wready});
    end
    tick();
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_single_b got=%b required=0", bvalid); end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d;
    axi_write(6'h00, 32'hAABBCCDD, 4'hF, r);
    axi_write(6'h00, 32'h11223344, 4'b0101, r);
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'hAA22CC44 || r !== 2'b00) begin
      bad++; $display("FAIL strobe_read got=%h/%b required=aa22cc44/00", d, r);
    end
    total++;
    if (cfg_out[31:0] !== 32'hAA22CC44) begin bad++; $display("FAIL strobe_cfg got=%h required=aa22cc44", cfg_out[31:0]); end
  endtask

  task automatic test_irq();
    logic [1:0] r; logic [31:0] d;
    axi_write(6'h1C, 32'h4, 4'hF, r);
    event_in = 4'h4; tick(); event_in = 4'h0;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency got=%b required=0", irq); end
    tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b required=1", irq); end
    axi_read(6'h18, d, r);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL irq_stat_read got=%h required=00000004", d); end
    axi_write(6'h18, 32'h4, 4'hF, r);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c_fall got=%b required=0", irq); end
    // Set bits 0 and 2, then clear both while bit 2 fires again in the same cycle
    event_in = 4'h5; tick(); event_in = 4'h0; tick();
    awaddr = 6'h18; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0; event_in = 4'h4;
    tick(); event_in = 4'h0;
    total++;
    if (bvalid !== 1'b1) begin bad++; $display("FAIL irq_race_bvalid got=%b required=1", bvalid); end
    bready = 1; tick(); bready = 0;
    axi_read(6'h18, d, r);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL irq_race_stat got=%h required=00000004", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_race_level got=%b required=1", irq); end
    axi_write(6'h1C, 32'hFFFFFFFF, 4'hF, r);
    axi_read(6'h1C, d, r);
    total++;
    if (d !== 32'hF) begin bad++; $display("FAIL irq_en_width got=%h required=0000000f", d); end
    axi_write(6'h18, 32'hF, 4'hF, r);
  endtask

  task automatic test_map();
    logic [1:0] r; logic [31:0] d;
    axi_read(6'h24, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL map_read_oob got=%h/%b required=00000000/10", d, r); end
    axi_read(6'h3C, d, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL map_read_top got=%b required=10", r); end
    axi_write(6'h10, 32'hFFFF, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL map_write_status_resp got=%b required=00", r); end
    axi_read(6'h10, d, r);
    total++;
    if (d !== 32'hAAAA0004 || r !== 2'b00) begin bad++; $display("FAIL map_status0 got=%h/%b required=aaaa0004/00", d, r); end
    axi_read(6'h14, d, r);
    total++;
    if (d !== 32'hBBBB0005) begin bad++; $display("FAIL map_status1 got=%h required=bbbb0005", d); end
    axi_write(6'h24, 32'h99, 4'hF, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL map_write_oob_resp got=%b required=10", r); end
    total++;
    if (cfg_out !== {32'h4, 32'h3, 32'h55, 32'hAA22CC44}) begin
      bad++; $display("FAIL map_no_alias got=%h required=%h", cfg_out, {32'h4, 32'h3, 32'h55, 32'hAA22CC44});
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 6'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    tick(); awvalid = 0; wvalid = 0;
    tick();
    total++;
    if (bvalid !== 1'b1 || cfg_out[95:64] !== 32'h77) begin
      bad++; $display("FAIL rstmid_pending got=%b/%h required=1/00000077", bvalid, cfg_out[95:64]);
    end
    areset = 1; tick();
    total++;
    if ({bvalid, awready, wready, arready, irq} !== 5'b0 || cfg_out !== RST_VAL) begin
      bad++; $display("FAIL rstmid_reset got=%b/%h required=00000/%h", {bvalid, awready, wready, arready, irq}, cfg_out, RST_VAL);
    end
    tick(); areset = 0; tick();
    total++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) begin
      bad++; $display("FAIL rstmid_release got=%b required=0111", {bvalid, awready, wready, arready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strobe();
    test_irq();
    test_map();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
